// File: rtl/guess_capture.sv
// Player-input side of the memory game: debounces the load button, captures switch
// entries against a pushed expected sequence and scores them (positional + multiset).
module guess_capture #(
  parameter int SEQ_LEN    = 3,
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] predict,
  input  logic             load_btn,
  output logic [WIDTH-1:0] echo_led,
  output logic             busy,
  output logic [2:0]       entry_idx,
  output logic             done,
  output logic [3:0]       score,
  output logic             exact,
  output logic [7:0]       result_led
);

  localparam int AW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [3:0] LEN4 = 4'(SEQ_LEN);
  localparam logic [3:0] LAST = 4'(SEQ_LEN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_EVAL    = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;

  logic          r_btn_meta, r_btn_sync, r_btn_stable, r_btn_stable_d;
  logic [CW-1:0] r_deb_cnt;
  logic          w_press;

  logic [2:0]         r_state;
  logic [WIDTH-1:0]   r_exp_mem   [SEQ_LEN];
  logic [WIDTH-1:0]   r_guess_mem [SEQ_LEN];
  logic [3:0]         r_wr_ptr, r_entry_idx, r_eval_idx, r_score;
  logic [SEQ_LEN-1:0] r_used;
  logic               r_set_miss, r_done, r_exact;
  logic [7:0]         r_result_led;
  logic [WIDTH-1:0]   r_echo;

  logic [WIDTH-1:0]   w_exp_cur, w_guess_cur;
  logic [SEQ_LEN-1:0] w_match, w_pick;
  logic               w_pos_hit, w_found, w_miss_next;
  logic [3:0]         w_score_next;

  // Level must differ from the accepted level for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_meta     <= 1'b0;
      r_btn_sync     <= 1'b0;
      r_btn_stable   <= 1'b0;
      r_btn_stable_d <= 1'b0;
      r_deb_cnt      <= '0;
    end else begin
      r_btn_meta     <= load_btn;
      r_btn_sync     <= r_btn_meta;
      r_btn_stable_d <= r_btn_stable;
      if (r_btn_sync == r_btn_stable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == CW'(DEB_CYCLES - 1)) begin
        r_btn_stable <= r_btn_sync;
        r_deb_cnt    <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + CW'(1);
      end
    end
  end

  assign w_press = r_btn_stable & ~r_btn_stable_d;

  assign w_exp_cur    = r_exp_mem[r_eval_idx[AW-1:0]];
  assign w_guess_cur  = r_guess_mem[r_eval_idx[AW-1:0]];
  assign w_pos_hit    = (w_guess_cur == w_exp_cur);
  assign w_score_next = r_score + {3'b000, w_pos_hit};

  genvar gi;
  generate
    for (gi = 0; gi < SEQ_LEN; gi++) begin : g_match
      assign w_match[gi] = (r_exp_mem[gi] == w_guess_cur) && !r_used[gi];
    end
  endgenerate

  // Isolate the lowest set bit: the lowest unused matching expected slot.
  assign w_pick      = w_match & (~w_match + SEQ_LEN'(1));
  assign w_found     = |w_match;
  assign w_miss_next = r_set_miss | ~w_found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_entry_idx  <= '0;
      r_eval_idx   <= '0;
      r_score      <= '0;
      r_used       <= '0;
      r_set_miss   <= 1'b0;
      r_done       <= 1'b0;
      r_exact      <= 1'b0;
      r_result_led <= '0;
      r_echo       <= '0;
      for (int k = 0; k < SEQ_LEN; k++) begin
        r_exp_mem[k]   <= '0;
        r_guess_mem[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_echo <= (r_state == S_CAPTURE) ? predict : '0;
      if (arm) begin
        r_state      <= S_LOAD;
        r_wr_ptr     <= '0;
        r_entry_idx  <= '0;
        r_eval_idx   <= '0;
        r_score      <= '0;
        r_exact      <= 1'b0;
        r_used       <= '0;
        r_set_miss   <= 1'b0;
        r_result_led <= '0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (exp_valid && r_wr_ptr != LEN4) begin
              r_exp_mem[r_wr_ptr[AW-1:0]] <= exp_data;
              r_wr_ptr <= r_wr_ptr + 4'd1;
              if (r_wr_ptr == LAST) r_state <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (w_press && r_entry_idx != LEN4) begin
              r_guess_mem[r_entry_idx[AW-1:0]] <= predict;
              r_entry_idx <= r_entry_idx + 4'd1;
              if (r_entry_idx == LAST) begin
                r_state    <= S_EVAL;
                r_eval_idx <= '0;
              end
            end
          end
          S_EVAL: begin
            r_score    <= w_score_next;
            r_used     <= r_used | w_pick;
            r_set_miss <= w_miss_next;
            if (r_eval_idx == LAST) begin
              r_state      <= S_REPORT;
              r_eval_idx   <= '0;
              r_done       <= 1'b1;
              r_exact      <= (w_score_next == LEN4);
              r_result_led <= (w_score_next == LEN4) ? 8'hFF :
                              (!w_miss_next ? 8'hAA : 8'h0F);
            end else begin
              r_eval_idx <= r_eval_idx + 4'd1;
            end
          end
          S_REPORT: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign echo_led   = r_echo;
  assign busy       = (r_state != S_IDLE);
  assign entry_idx  = r_entry_idx[2:0];
  assign done       = r_done;
  assign score      = r_score;
  assign exact      = r_exact;
  assign result_led = r_result_led;

endmodule
